// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART: word, done strobe and status flags.
// Macro UART_RX_PARITY_EN adds the parity-error flag.
interface uart_rx_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] o_data;
    logic             o_rx_done;
    logic             o_frame_err;
    logic             o_busy;
`ifdef UART_RX_PARITY_EN
    logic             o_parity_err;
`endif

    modport master (
        output o_data,
        output o_rx_done,
        output o_frame_err,
`ifdef UART_RX_PARITY_EN
        output o_parity_err,
`endif
        output o_busy
    );

    modport slave (
        input o_data,
        input o_rx_done,
        input o_frame_err,
`ifdef UART_RX_PARITY_EN
        input o_parity_err,
`endif
        input o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver, LSB first, one-clk done strobe.
// Macro UART_RX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_rx #(
    parameter int NBITS = 8,
    parameter int TICKS = 16
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_baud_rate,
    input  logic     i_rx,
    uart_rx_if.master bus
);
    localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int BW = $clog2(NBITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(TICKS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [TW-1:0]    tick;
    logic [BW-1:0]    bitc;
    logic [NBITS-1:0] shreg;
    logic             sync1;
    logic             rx_s;
`ifdef UART_RX_PARITY_EN
    logic             par;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            tick            <= '0;
            bitc            <= '0;
            shreg           <= '0;
            sync1           <= 1'b1;
            rx_s            <= 1'b1;
            bus.o_data      <= '0;
            bus.o_rx_done   <= 1'b0;
            bus.o_frame_err <= 1'b0;
            bus.o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par              <= 1'b0;
            bus.o_parity_err <= 1'b0;
`endif
        end else begin
            sync1         <= i_rx;
            rx_s          <= sync1;
            bus.o_rx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state      <= START;
                        tick       <= '0;
                        bus.o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (i_baud_rate) begin
                        if (tick == TICK_MID) begin
                            tick <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                                bitc  <= '0;
                            end else begin
                                state      <= IDLE;
                                bus.o_busy <= 1'b0;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (i_baud_rate) begin
                        if (tick == TICK_LAST) begin
                            tick  <= '0;
                            bitc  <= bitc + 1'b1;
                            shreg <= {rx_s, shreg[NBITS-1:1]};
                            if (bitc == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (i_baud_rate) begin
                        if (tick == TICK_LAST) begin
                            tick  <= '0;
                            par   <= rx_s;
                            state <= STOP;
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (i_baud_rate) begin
                        if (tick == TICK_LAST) begin
                            tick            <= '0;
                            bus.o_data      <= shreg;
                            bus.o_frame_err <= ~rx_s;
                            bus.o_rx_done   <= 1'b1;
                            bus.o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            bus.o_parity_err <= (^shreg) ^ par;
`endif
                            state <= IDLE;
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    tick       <= '0;
                    bus.o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clks, 64 clks per bit.
// Macro UART_RX_PARITY_EN also exercises the parity flag.
module tb_uart_rx;
    localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN     = 1'b1;
    localparam int FRAME_BITS = 11;
`else
    localparam bit PAR_EN     = 1'b0;
    localparam int FRAME_BITS = 10;
`endif

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic baud = 1'b0;
    logic rx   = 1'b1;

    uart_rx_if #(.NBITS(8)) bus ();

    uart_rx #(
        .NBITS(8),
        .TICKS(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_baud_rate(baud),
        .i_rx       (rx),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            baud = (k % 4 == 0);
        end
    end

    int         done_cnt = 0;
    logic [7:0] got_data [16];
    logic       got_ferr [16];
    int         got_t    [16];
    logic       busy_post = 1'b1;
    logic       done_prev = 1'b0;

    always @(negedge clk) begin
        if (done_prev) busy_post = bus.o_busy;
        if (bus.o_rx_done) begin
            if (done_cnt < 16) begin
                got_data[done_cnt] = bus.o_data;
                got_ferr[done_cnt] = bus.o_frame_err;
                got_t[done_cnt]    = cyc;
            end
            done_cnt++;
        end
        done_prev = bus.o_rx_done;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // A bad stop bit is driven low only past its mid-bit sample.
    task automatic send_frame(input logic [7:0] d,
                              input logic par,
                              input logic stop);
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
        if (PAR_EN) hold(par, BIT_CLKS);
        if (stop) begin
            hold(1'b1, BIT_CLKS);
        end else begin
            hold(1'b0, 40);
            hold(1'b1, BIT_CLKS - 40);
        end
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, ^d, 1'b1);
    endtask

    initial begin
        int base;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data", bus.o_data, 8'h00);
        check("rst_done", bus.o_rx_done, 1'b0);
        check("rst_ferr", bus.o_frame_err, 1'b0);
        check("rst_busy", bus.o_busy, 1'b0);

        hold(1'b0, 16);
        hold(1'b1, 150);
        check("glitch_cnt", done_cnt, 0);
        check("glitch_data", bus.o_data, 8'h00);
        check("glitch_busy", bus.o_busy, 1'b0);

        base = done_cnt;
        send_good(8'hA5);
        hold(1'b1, 64);
        check("a5_cnt", done_cnt, base + 1);
        check("a5_data", got_data[base], 8'hA5);
        check("a5_ferr", got_ferr[base], 1'b0);
        check("a5_busy_after", busy_post, 1'b0);

        base = done_cnt;
        send_frame(8'h3C, ^8'h3C, 1'b0);
        hold(1'b1, 128);
        check("3c_cnt", done_cnt, base + 1);
        check("3c_data", got_data[base], 8'h3C);
        check("3c_ferr", got_ferr[base], 1'b1);
        check("3c_held_ferr", bus.o_frame_err, 1'b1);

        base = done_cnt;
        send_good(8'h11);
        hold(1'b1, 64);
        check("11_cnt", done_cnt, base + 1);
        check("11_data", got_data[base], 8'h11);
        check("11_ferr", got_ferr[base], 1'b0);

        base = done_cnt;
        send_good(8'h00);
        send_good(8'hFF);
        hold(1'b1, 64);
        check("b2b_cnt", done_cnt, base + 2);
        check("b2b_data0", got_data[base], 8'h00);
        check("b2b_data1", got_data[base+1], 8'hFF);
        check("b2b_ferr1", got_ferr[base+1], 1'b0);
        check("b2b_gap", got_t[base+1] - got_t[base],
              FRAME_BITS * BIT_CLKS);

        base = done_cnt;
        d = 8'h5A;
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) hold(d[i], BIT_CLKS);
        hold(d[3], BIT_CLKS / 2);
        check("5a_busy_mid", bus.o_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 6 * BIT_CLKS);
        check("5a_cnt", done_cnt, base);
        check("5a_data", bus.o_data, 8'h00);
        check("5a_ferr", bus.o_frame_err, 1'b0);
        check("5a_busy", bus.o_busy, 1'b0);

        send_good(8'h81);
        hold(1'b1, 64);
        check("81_cnt", done_cnt, base + 1);
        check("81_data", got_data[base], 8'h81);
        check("81_ferr", got_ferr[base], 1'b0);

`ifdef UART_RX_PARITY_EN
        base = done_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        hold(1'b1, 64);
        check("par_ok_cnt", done_cnt, base + 1);
        check("par_ok_err", bus.o_parity_err, 1'b0);
        check("par_ok_data", bus.o_data, 8'h07);
        send_frame(8'h07, 1'b0, 1'b1);
        hold(1'b1, 64);
        check("par_bad_cnt", done_cnt, base + 2);
        check("par_bad_err", bus.o_parity_err, 1'b1);
        check("par_bad_data", bus.o_data, 8'h07);
        check("par_bad_ferr", bus.o_frame_err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; the receive-side counterpart of the team's 16x-oversampled UART transmitter in the BIP serial link.
- Deserializes an LSB-first frame from the line: start bit (0), NBITS data bits, optional parity bit, stop bit (1).
- Uses the shared baud-rate tick generator; i_baud_rate is a 1-clk strobe at TICKS x bit rate.
- Presents each received byte with a one-cycle done strobe to the BIP I/O logic.

Parameters:
NBITS, 8, data bits per frame.
TICKS, 16, baud ticks per bit period; even, >= 4.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous reset, active-high (fixed decision).
i_baud_rate  input  1  oversample tick strobe, 1 clk wide.
i_rx  input  1  serial line, asynchronous, idle high.
o_data  output  NBITS  last received word; held until next frame completes.
o_rx_done  output  1  1-clk pulse, frame complete.
o_frame_err  output  1  stop bit sampled 0; valid with o_rx_done, held until next o_rx_done.
o_busy  output  1  high in any state other than idle.

Behaviour:
Reset and synchronizer:
- rst high at a clk edge: state=idle, tick/bit counters=0, shift reg=0, o_data=0, o_rx_done=0, o_frame_err=0, o_busy=0, both synchronizer flops=1.
- Reset mid-frame aborts the frame silently; no o_rx_done.
- i_rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s.
- Counters advance only on clk cycles with i_baud_rate=1; rx_s is sampled only on those cycles.

States: idle, start, data, stop (plus parity, see Optional Feature).
- idle: on any cycle with rx_s==0 (tick not required) -> start; tick=0.
- start: on tick, if tick==TICKS/2-1 check rx_s:
  - rx_s==0 -> data, tick=0, bit=0.
  - rx_s==1 -> false start, back to idle, no output change.
  - otherwise tick++.
- data: on tick, if tick==TICKS-1: shift reg <= {rx_s, shreg[NBITS-1:1]} (LSB first), tick=0, bit++. When bit==NBITS-1 is sampled -> stop. Otherwise tick++.
  - Samples therefore fall at mid-bit.
- stop: on tick, if tick==TICKS-1:
  - o_data<=shreg, o_frame_err<=~rx_s, o_rx_done<=1, -> idle.
  - A frame with a bad stop bit still updates o_data and pulses done.
- o_rx_done is registered and high exactly one clk: the cycle after the stop-sample edge.
- Back-to-back frames: idle accepts a new start on the first cycle after return to idle. With the stop bit sampled mid-bit, the next start edge is not missed.
- Line held low forever (break): one frame_err frame, then repeated frame_err frames of 0x00 every frame time.
- o_busy = (state != idle), registered with state.
- Bit counter sized to hold NBITS; tick counter sized to hold TICKS-1. No wrap occurs within a frame.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined:
  - State parity is inserted between data and stop; one bit sampled at tick==TICKS-1.
  - Adds output o_parity_err (1 bit, reset 0).
  - At the stop sample, o_parity_err <= (^shreg) ^ parity_bit (even parity; 1 = mismatch). Updated and held like o_frame_err.
- Undefined: no parity state, no o_parity_err port; frame is start+NBITS+stop.

Test Plan:
- Tick every 4 clks; send 0xA5 with a good stop -> single o_rx_done pulse, o_data=0xA5, o_frame_err=0, o_busy low 1 clk after the done cycle.
- Line low for 4 ticks, then high (glitch) -> no o_rx_done, state returns to idle, o_data unchanged (0x00 after reset).
- Send 0x3C with stop bit=0 -> o_rx_done pulse, o_data=0x3C, o_frame_err=1. Next good frame 0x11 -> o_frame_err=0.
- Back-to-back 0x00 then 0xFF, zero idle gap -> two done pulses exactly one frame time (10*16 ticks) apart, data 0x00 then 0xFF.
- Assert rst for 1 clk during data bit 3 of 0x5A -> outputs hold reset values, no done. Following frame 0x81 received correctly.
- UART_RX_PARITY_EN: 0x07 with parity 1 -> o_parity_err=0; same byte with parity 0 -> o_parity_err=1, o_data=0x07.
